// File: rtl/risc_pkg.sv
// Shared constants, arbiter state type and tie-break helper for the RISC core memory system.
// The arbiter and its testbench both import this package.
package risc_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int RAM_WORDS = 256;

    localparam logic [ADDR_W-1:0] SW_ADDR   = 9'h140;
    localparam logic [ADDR_W-1:0] LEDR_ADDR = 9'h100;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RDATA  = 2'd2
    } arb_state_t;

    // A lone requester always wins; on a tie the port that was not served last wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        if (req == 2'b10) return 1'b1;
        if (req == 2'b01) return 1'b0;
        return ~last;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM with a registered, read-before-write output.
// Contents have no reset; o_q holds its value while i_en is low.
module ram_sp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            o_q <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port RAM and memory-mapped I/O between CPU (port 0) and loader (port 1).
// gnt one cycle after req is sampled, rvalid one cycle later; requesters hold req until gnt.
module mem_arbiter #(
    parameter int                     ADDR_W    = risc_pkg::ADDR_W,
    parameter int                     DATA_W    = risc_pkg::DATA_W,
    parameter int                     RAM_WORDS = risc_pkg::RAM_WORDS,
    parameter logic [ADDR_W-1:0]      SW_ADDR   = risc_pkg::SW_ADDR,
    parameter logic [ADDR_W-1:0]      LEDR_ADDR = risc_pkg::LEDR_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr
);

    import risc_pkg::*;

    localparam int RAM_AW = $clog2(RAM_WORDS);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_sel;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_ledr;

    logic              w_win;
    logic              w_accept;
    logic              w_ram_hit;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_win     = pick_winner(req, r_last);
    assign w_accept  = (r_state == ARB_IDLE) && (|req);
    // Extra top bit keeps the compare correct even when RAM_WORDS == 2**ADDR_W.
    assign w_ram_hit = ({1'b0, r_addr} < (ADDR_W + 1)'(RAM_WORDS));
    assign w_ram_en  = (r_state == ARB_ACCESS);
    assign w_ram_we  = w_ram_en && r_we && w_ram_hit;
    assign ledr      = r_ledr;

    always_comb begin
        w_rd_mux = '0;
        if (w_ram_hit) begin
            w_rd_mux = w_ram_q;
        end else if (r_addr == SW_ADDR) begin
            w_rd_mux = {{(DATA_W - 8){1'b0}}, sw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = 2'b00;
        rvalid      = 2'b00;
        rdata       = '0;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                gnt[r_sel]  = 1'b1;
                w_state_nxt = r_we ? ARB_IDLE : ARB_RDATA;
            end
            ARB_RDATA: begin
                rvalid[r_sel] = 1'b1;
                rdata         = w_rd_mux;
                w_state_nxt   = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // The request is captured once in IDLE; later req/addr changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_sel   <= w_win;
            r_we    <= w_win ? we[1] : we[0];
            r_addr  <= w_win ? addr1 : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
        end
    end

    // last resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
            r_ledr <= 8'h00;
        end else if (r_state == ARB_ACCESS) begin
            r_last <= r_sel;
            if (r_we && (r_addr == LEDR_ADDR)) begin
                r_ledr <= r_wdata[7:0];
            end
        end
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[RAM_AW-1:0]),
        .i_wdata (r_wdata),
        .o_q     (w_ram_q)
    );

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_rvalid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid));
    a_gnt_rvalid_excl: assert property (@(posedge clk) disable iff (!rst_n) !((|gnt) && (|rvalid)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of memory, LEDs and round-robin order.
module tb_mem_arbiter;

    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [8:0]  addr0 = '0;
    logic [8:0]  addr1 = '0;
    logic [15:0] wdata0 = '0;
    logic [15:0] wdata1 = '0;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  ledr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .sw     (sw),
        .ledr   (ledr)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mdl_mem [256];
    int          mdl_last = 1;
    logic [7:0]  mdl_ledr = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mdl_read(input logic [8:0] a);
        if (a < 9'd256) return mdl_mem[a[7:0]];
        if (a == SW_ADDR) return {8'h00, sw};
        return 16'h0000;
    endfunction

    function automatic void mdl_write(input logic [8:0] a, input logic [15:0] d);
        if (a < 9'd256) mdl_mem[a[7:0]] = d;
        else if (a == LEDR_ADDR) mdl_ledr = d[7:0];
    endfunction

    function automatic logic [1:0] port_mask(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [8:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return SW_ADDR;
            1:       return LEDR_ADDR;
            2:       return 9'($urandom);
            default: return {1'b0, 8'($urandom)};
        endcase
    endfunction

    task automatic drive_port(input int p, input bit w, input logic [8:0] a, input logic [15:0] d);
        if (p == 1) begin
            req[1] = 1'b1; we[1] = w; addr1 = a; wdata1 = d;
        end else begin
            req[0] = 1'b1; we[0] = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic scramble_ports();
        req    = 2'b00;
        we     = 2'($urandom);
        addr0  = 9'($urandom);
        addr1  = 9'($urandom);
        wdata0 = 16'($urandom);
        wdata1 = 16'($urandom);
    endtask

    // Single transaction from an idle arbiter; called just after a falling edge.
    task automatic do_txn(input int p, input bit w, input logic [8:0] a, input logic [15:0] d,
                          input string tag);
        logic [15:0] exp;
        drive_port(p, w, a, d);
        @(negedge clk);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(port_mask(p)));
        mdl_last = p;
        exp = mdl_read(a);
        if (w) mdl_write(a, d);
        scramble_ports();
        @(negedge clk);
        if (w) begin
            check_eq({tag, ".ledr"}, 32'(ledr), 32'(mdl_ledr));
            check_eq({tag, ".wr_idle"}, 32'({gnt, rvalid}), 32'h0);
        end else begin
            check_eq({tag, ".rvalid"}, 32'(rvalid), 32'(port_mask(p)));
            check_eq({tag, ".rdata"}, 32'(rdata), 32'(exp));
            @(negedge clk);
            check_eq({tag, ".rd_idle"}, 32'({gnt, rvalid}), 32'h0);
        end
    endtask

    // Both ports hold their request; grants must alternate with 2/3-cycle spacing.
    task automatic contention(input int n_grants, input bit w0, input bit w1, input string tag);
        int          got = 0;
        int          cyc = 0;
        int          last_cyc = 0;
        int          exp_p;
        bit          prev_w = 1'b0;
        logic [1:0]  pend = 2'b00;
        logic [15:0] pexp = '0;
        logic [8:0]  pa [2];
        logic [15:0] pd [2];
        bit          pw [2];
        pa[0] = rand_addr(); pa[1] = rand_addr();
        pd[0] = 16'($urandom); pd[1] = 16'($urandom);
        pw[0] = w0; pw[1] = w1;
        drive_port(0, pw[0], pa[0], pd[0]);
        drive_port(1, pw[1], pa[1], pd[1]);
        while ((got < n_grants || pend != 2'b00) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pend != 2'b00) begin
                check_eq({tag, ".rvalid"}, 32'(rvalid), 32'(pend));
                check_eq({tag, ".rdata"}, 32'(rdata), 32'(pexp));
                pend = 2'b00;
            end else if (gnt != 2'b00) begin
                exp_p = (mdl_last == 1) ? 0 : 1;
                check_eq({tag, ".gnt"}, 32'(gnt), 32'(port_mask(exp_p)));
                if (got > 0) check_eq({tag, ".spacing"}, cyc - last_cyc, prev_w ? 2 : 3);
                if (pw[exp_p]) mdl_write(pa[exp_p], pd[exp_p]);
                else begin
                    pend = port_mask(exp_p);
                    pexp = mdl_read(pa[exp_p]);
                end
                prev_w   = pw[exp_p];
                last_cyc = cyc;
                mdl_last = exp_p;
                got++;
            end
        end
        check_eq({tag, ".count"}, got, n_grants);
        scramble_ports();
        @(negedge clk);
        check_eq({tag, ".idle"}, 32'({gnt, rvalid}), 32'h0);
        check_eq({tag, ".ledr"}, 32'(ledr), 32'(mdl_ledr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mem5;
        repeat (3) @(negedge clk);
        check_eq("reset.gnt", 32'(gnt), 32'h0);
        check_eq("reset.rvalid", 32'(rvalid), 32'h0);
        check_eq("reset.rdata", 32'(rdata), 32'h0);
        check_eq("reset.ledr", 32'(ledr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload RAM through the loader port so every word has a known value.
        for (int i = 0; i < 256; i++) begin
            do_txn(1, 1'b1, 9'(i), (i == 0) ? 16'hD008 : 16'($urandom), "fill");
        end

        // Reset keeps RAM; first read of word 0 after release.
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("reset2.gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        mdl_last = 1; mdl_ledr = 8'h00;
        @(negedge clk);
        do_txn(0, 1'b0, 9'h000, 16'h0, "t1.rd0");

        do_txn(0, 1'b1, 9'h009, 16'd48, "t2.wr9");
        do_txn(0, 1'b0, 9'h009, 16'h0, "t2.rd9");

        do_txn(1, 1'b0, 9'h003, 16'h0, "t3.pre");
        contention(8, 1'b0, 1'b0, "t3.rr");

        sw = 8'hA5;
        do_txn(0, 1'b0, SW_ADDR, 16'h0, "t4.sw");
        do_txn(1, 1'b1, LEDR_ADDR, 16'h1234, "t4.ledr_wr");
        check_eq("t4.ledr_val", 32'(ledr), 32'h34);
        do_txn(0, 1'b0, LEDR_ADDR, 16'h0, "t4.ledr_rd");
        do_txn(1, 1'b1, SW_ADDR, 16'h7777, "t4.sw_wr");
        do_txn(0, 1'b0, SW_ADDR, 16'h0, "t4.sw_rd2");

        // Reset pulse while a write is in ACCESS.
        mem5 = mdl_mem[5];
        drive_port(1, 1'b1, 9'h005, 16'hBEEF);
        @(negedge clk);
        check_eq("t5.gnt", 32'(gnt), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5.gnt_rst", 32'(gnt), 32'h0);
        check_eq("t5.ledr_rst", 32'(ledr), 32'h0);
        rst_n = 1'b1;
        scramble_ports();
        mdl_last = 1; mdl_ledr = 8'h00;
        @(negedge clk);
        drive_port(0, 1'b0, 9'h005, 16'h0);
        drive_port(1, 1'b0, 9'h006, 16'h0);
        @(negedge clk);
        check_eq("t5.tie_gnt", 32'(gnt), 32'(2'b01));
        mdl_last = 0;
        scramble_ports();
        @(negedge clk);
        check_eq("t5.rvalid", 32'(rvalid), 32'(2'b01));
        check_eq("t5.mem5", 32'(rdata), 32'(mem5));
        @(negedge clk);

        do_txn(0, 1'b1, 9'h1FF, 16'hFFFF, "t6.wr_unmapped");
        do_txn(0, 1'b0, 9'h1FF, 16'h0, "t6.rd_unmapped");
        do_txn(1, 1'b0, 9'h0FF, 16'h0, "t6.rd_ff");
        do_txn(0, 1'b0, 9'h07F, 16'h0, "t6.rd_7f");

        for (int it = 0; it < 40; it++) begin
            sw = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                contention($urandom_range(2, 6), 1'($urandom), 1'($urandom), "rnd.ctn");
            end else begin
                do_txn($urandom_range(0, 1), 1'($urandom), rand_addr(), 16'($urandom), "rnd.txn");
            end
        end

        for (int i = 0; i < 256; i += 17) begin
            do_txn(i % 2, 1'b0, 9'(i), 16'h0, "final.rd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
